// File: rtl/div_32_bit_seq_pkg.sv
// Shared definitions for the sequential divider: FSM encoding and iteration sizing.
// The sequential multiplier reuses the same state encoding.
package div_32_bit_seq_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int DIV_ITER_W = $clog2(DIV_WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_32_bit_seq_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor,
// keep the difference when it is non-negative. The compare is WIDTH+1 bits wide so that
// divisors with the MSB set are handled correctly.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] d;

    // Trial subtraction and restore select.
    always_comb begin
        t        = {rem, q_msb};
        d        = t - {1'b0, divisor};
        q_bit    = ~d[WIDTH];
        rem_next = q_bit ? d[WIDTH-1:0] : t[WIDTH-1:0];
    end

endmodule

// File: rtl/div_32_bit_seq.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, done pulse on completion.
// state  | meaning
// IDLE   | waiting for start; results held
// RUN    | iterating, one quotient bit per edge
// DONE   | one-cycle done pulse, results valid
module div_32_bit_seq
    import div_32_bit_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] qr_q, qr_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .q_msb    (qr_q[WIDTH-1]),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .q_bit    (step_bit)
    );

    // Next-state and datapath update; the divide-by-zero case bypasses RUN.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        qr_d    = qr_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        dvs_d   = divisor;
                        rem_d   = '0;
                        qr_d    = dividend;
                        count_d = '0;
                        dbz_d   = 1'b0;
                        state_d = S_RUN;
                    end else begin
                        quot_d  = '1;
                        remo_d  = dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                rem_d   = step_rem;
                qr_d    = {qr_q[WIDTH-2:0], step_bit};
                count_d = count_q + 1'b1;
                if (count_q == CNT_LAST) begin
                    quot_d  = {qr_q[WIDTH-2:0], step_bit};
                    remo_d  = step_rem;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            rem_q   <= '0;
            qr_q    <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            qr_q    <= qr_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
        end
    end

    // Status decoded directly from state so busy rises on the edge after acceptance.
    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        quotient    = quot_q;
        remainder   = remo_q;
        div_by_zero = dbz_q;
    end

endmodule

// File: tb/tb_div_32_bit_seq.sv
module tb_div_32_bit_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
    } exp_t;

    exp_t sb[$];

    div_32_bit_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.z = 1'b1; e.lat = 0;
        end else begin
            e.q = a / b; e.r = a % b; e.z = 1'b0; e.lat = 32;
        end
        return e;
    endfunction

    // Drives one operation from IDLE; lat counts negedges after the accepting edge until done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r, output logic z,
                          output int lat, output bit to);
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        to = (done !== 1'b1);
        q = quotient; r = remainder; z = div_by_zero;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b dbz=%b q=%h r=%h required all zero",
                     busy, done, div_by_zero, quotient, remainder);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        exp_t e;
        int lat;
        e = model(32'd100, 32'd7);
        sb.push_back(e);
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL basic_busy_pre: got %b required 0", busy);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL basic_busy_post: busy=%b done=%b required 1/0", busy, done);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat || quotient !== e.q || remainder !== e.r || div_by_zero !== e.z) begin
            failures++;
            $display("FAIL basic_100_7: lat=%0d q=%0d r=%0d z=%b required lat=%0d q=%0d r=%0d z=%b",
                     lat, quotient, remainder, div_by_zero, e.lat, e.q, e.r, e.z);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || quotient !== e.q || remainder !== e.r) begin
            failures++;
            $display("FAIL basic_after_done: done=%b busy=%b q=%0d r=%0d required 0/0 held %0d/%0d",
                     done, busy, quotient, remainder, e.q, e.r);
        end
    endtask

    // Boundary, divide-by-zero and small-operand cases through the scoreboard.
    task automatic test_table(input string name, input logic [31:0] as[], input logic [31:0] bs[]);
        logic [31:0] q, r;
        logic z;
        int lat;
        bit to;
        exp_t e;
        for (int i = 0; i < as.size(); i++) begin
            sb.push_back(model(as[i], bs[i]));
            run_op(as[i], bs[i], q, r, z, lat, to);
            e = sb.pop_front();
            checks++;
            if (to || lat !== e.lat || q !== e.q || r !== e.r || z !== e.z) begin
                failures++;
                $display("FAIL %s[%0d] %h/%h: to=%0b lat=%0d q=%h r=%h z=%b required lat=%0d q=%h r=%h z=%b",
                         name, i, e.a, e.b, to, lat, q, r, z, e.lat, e.q, e.r, e.z);
            end
        end
    endtask

    task automatic test_ignore_start;
        exp_t e;
        int lat;
        sb.push_back(model(32'd100, 32'd7));
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        dividend = 32'd50; divisor = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 5;
        while (done !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat || quotient !== e.q || remainder !== e.r || div_by_zero !== e.z) begin
            failures++;
            $display("FAIL ignore_start: lat=%0d q=%0d r=%0d required lat=%0d q=%0d r=%0d",
                     lat, quotient, remainder, e.lat, e.q, e.r);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL ignore_no_queue: busy=%b required 0", busy);
        end
        test_table("after_ignore", '{32'd50}, '{32'd5});
    endtask

    task automatic test_reset_mid_run;
        int seen;
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_run: busy=%b done=%b q=%h r=%h required zeros",
                     busy, done, quotient, remainder);
        end
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++; $display("FAIL reset_no_done: done pulses=%0d required 0", seen);
        end
        test_table("after_reset", '{32'd9}, '{32'd3});
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int lat;
        sb.push_back(model(32'd200, 32'd9));
        sb.push_back(model(32'd77, 32'd0));
        @(negedge clk);
        dividend = 32'd200; divisor = 32'd9; start = 1'b1;
        lat = 0;
        while (done !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        checks++;
        if (lat !== 33 || quotient !== e.q || remainder !== e.r || div_by_zero !== e.z) begin
            failures++;
            $display("FAIL b2b_first: lat=%0d q=%0d r=%0d required lat=33 q=%0d r=%0d",
                     lat, quotient, remainder, e.q, e.r);
        end
        dividend = 32'd77; divisor = 32'd0;
        lat = 0;
        @(negedge clk);
        while (done !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        e = sb.pop_front();
        checks++;
        if (lat !== 1 || quotient !== e.q || remainder !== e.r || div_by_zero !== e.z) begin
            failures++;
            $display("FAIL b2b_second: lat=%0d q=%h r=%h z=%b required lat=1 q=%h r=%h z=%b",
                     lat, quotient, remainder, div_by_zero, e.q, e.r, e.z);
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick(input int sel);
        logic [31:0] bvals[5];
        bvals = '{32'd0, 32'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        case (sel)
            0:       return bvals[$urandom_range(4, 0)];
            1:       return 32'($urandom_range(300, 0));
            2:       return $urandom >> $urandom_range(31, 0);
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random;
        logic [31:0] a, b, q, r;
        logic z;
        int lat, bad;
        bit to;
        exp_t e;
        bad = 0;
        for (int i = 0; i < 1500; i++) begin
            a = pick($urandom_range(3, 0));
            b = ($urandom_range(19, 0) == 0) ? 32'd0 : pick($urandom_range(3, 0));
            sb.push_back(model(a, b));
            run_op(a, b, q, r, z, lat, to);
            e = sb.pop_front();
            checks++;
            if (to || lat !== e.lat || q !== e.q || r !== e.r || z !== e.z) begin
                failures++;
                if (bad < 10)
                    $display("FAIL random[%0d] %h/%h: to=%0b lat=%0d q=%h r=%h z=%b required lat=%0d q=%h r=%h z=%b",
                             i, a, b, to, lat, q, r, z, e.lat, e.q, e.r, e.z);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_table("boundary", '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000},
                               '{32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF});
        test_table("div_zero", '{32'd5, 32'd9}, '{32'd0, 32'd3});
        test_table("small", '{32'd3, 32'd0, 32'd1}, '{32'd10, 32'd9, 32'd1});
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
